// File: rtl/pulse_sync_sched_pkg.sv
// Shared definitions for the pulse synchronizer scheduler: FSM encoding and
// the round-robin search used by the arbiter.
package pulse_sync_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GUARD = 2'd2
    } state_t;

    localparam int RR_MAXN = 16;
    localparam int RR_IDXW = 4;

    // First set bit of pend searching upward from last+1 with wrap at nreq.
    // Returns last when nothing is pending; callers gate on |pend.
    function automatic logic [RR_IDXW-1:0] rr_next(
        input logic [RR_MAXN-1:0] pend,
        input int                 nreq,
        input logic [RR_IDXW-1:0] last
    );
        logic [RR_IDXW-1:0] idx;
        logic               found;
        rr_next = last;
        found   = 1'b0;
        for (int k = 1; k <= RR_MAXN; k++) begin
            idx = RR_IDXW'((int'(last) + k) % nreq);
            if ((k <= nreq) && !found && pend[idx]) begin
                rr_next = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/pulse_sync_sched_cnt.sv
// One requester's pending-pulse counter: saturating up/down with a sticky
// overflow flag that records events lost while saturated.
module pulse_pend_cnt #(
    parameter int CNTW = 3
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            inc,
    input  logic            dec,
    input  logic            clr_ovf,
    output logic [CNTW-1:0] cnt,
    output logic            ovf
);
    logic sat;
    logic ovf_set;

    always_comb begin
        sat     = &cnt;
        ovf_set = inc && !dec && sat;
    end

    // Simultaneous inc and dec cancel, even at saturation, so no event is lost.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            cnt <= '0;
            ovf <= 1'b0;
        end else begin
            case ({inc, dec})
                2'b10:   if (!sat) cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            ovf <= ovf_set || (ovf && !clr_ovf);
        end
    end

endmodule

// File: rtl/pulse_sync_sched.sv
// Shares one cross-domain pulse synchronizer among NREQ requesters: counts
// pending events, grants round-robin, and spaces pulses by a guard gap.
module pulse_sync_sched
    import pulse_sync_sched_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int CNTW = 3,
    parameter int GAP  = 6
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [NREQ-1:0] req_pulse,
    input  logic            enable,
    input  logic            clr_ovf,
    output logic            pulse_out,
    output logic [IDW-1:0]  pulse_id,
    output logic            busy,
    output logic [NREQ-1:0] pending,
    output logic [NREQ-1:0] ovf
);
    localparam int GW = 4;

    state_t               state;
    logic [IDW-1:0]       last;
    logic [GW-1:0]        gap_cnt;
    logic [CNTW-1:0]      cnt [NREQ];
    logic [NREQ-1:0]      dec;
    logic [RR_MAXN-1:0]   pend_ext;
    logic [RR_IDXW-1:0]   grant_w;
    logic [IDW-1:0]       grant;

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        assign dec[i]     = (state == ST_ISSUE) && (pulse_id == IDW'(i));
        assign pending[i] = |cnt[i];

        pulse_pend_cnt #(.CNTW(CNTW)) u_cnt (
            .clk     (clk),
            .rstn    (rstn),
            .inc     (req_pulse[i]),
            .dec     (dec[i]),
            .clr_ovf (clr_ovf),
            .cnt     (cnt[i]),
            .ovf     (ovf[i])
        );
    end

    always_comb begin
        pend_ext                = '0;
        pend_ext[NREQ-1:0]      = pending;
        grant_w                 = rr_next(pend_ext, NREQ, RR_IDXW'(last));
        grant                   = IDW'(grant_w);
    end

    // pulse_out decodes the state register directly, so it is glitch-free.
    assign pulse_out = (state == ST_ISSUE);
    assign busy      = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            pulse_id <= '0;
            last     <= IDW'(NREQ - 1);
            gap_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable && (|pending)) begin
                        pulse_id <= grant;
                        last     <= grant;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    gap_cnt <= GW'(GAP - 1);
                    state   <= ST_GUARD;
                end
                ST_GUARD: begin
                    if (gap_cnt == '0) state <= ST_IDLE;
                    else               gap_cnt <= gap_cnt - 1'b1;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pulse_sync_sched.sv
// Directed bench for pulse_sync_sched: latency, spacing, saturation,
// fairness and reset abort, checked with immediate assertions.
module tb_pulse_sync_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;
    localparam int CNTW = 3;
    localparam int GAP  = 6;

    logic            clk = 1'b0;
    logic            rstn;
    logic [NREQ-1:0] req_pulse;
    logic            enable;
    logic            clr_ovf;
    logic            pulse_out;
    logic [IDW-1:0]  pulse_id;
    logic            busy;
    logic [NREQ-1:0] pending;
    logic [NREQ-1:0] ovf;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pulse_sync_sched #(.NREQ(NREQ), .IDW(IDW), .CNTW(CNTW), .GAP(GAP)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .req_pulse (req_pulse),
        .enable    (enable),
        .clr_ovf   (clr_ovf),
        .pulse_out (pulse_out),
        .pulse_id  (pulse_id),
        .busy      (busy),
        .pending   (pending),
        .ovf       (ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        int  npulse;
        logic exp_p;

        rstn = 1'b0; req_pulse = '0; enable = 1'b0; clr_ovf = 1'b0;
        tick(); tick();
        chk("rst_pulse_out", 32'(pulse_out), 32'd0);
        chk("rst_pulse_id",  32'(pulse_id),  32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_pending",   32'(pending),   32'd0);
        chk("rst_ovf",       32'(ovf),       32'd0);
        rstn = 1'b1; enable = 1'b1;

        // Single request: pulse in cycle 2, busy 2..8.
        req_pulse = 4'b0001;
        tick(); req_pulse = '0;
        chk("lat_c1_pulse",   32'(pulse_out), 32'd0);
        chk("lat_c1_pending", 32'(pending),   32'b0001);
        tick();
        chk("lat_c2_pulse",   32'(pulse_out), 32'd1);
        chk("lat_c2_id",      32'(pulse_id),  32'd0);
        chk("lat_c2_busy",    32'(busy),      32'd1);
        tick();
        chk("lat_c3_pulse",   32'(pulse_out), 32'd0);
        chk("lat_c3_pending", 32'(pending),   32'd0);
        chk("lat_c3_busy",    32'(busy),      32'd1);
        for (int c = 4; c <= 9; c++) begin
            tick();
            chk("lat_busy", 32'(busy), 32'(c <= 8));
            chk("lat_nopulse", 32'(pulse_out), 32'd0);
        end

        // Fresh reset so requester 0 has first priority again.
        rstn = 1'b0; tick(); rstn = 1'b1;
        req_pulse = 4'b1111;
        tick(); req_pulse = '0;
        for (int c = 2; c <= 34; c++) begin
            tick();
            exp_p = (c >= 2) && (c <= 26) && (((c - 2) % 8) == 0);
            chk("all4_pulse", 32'(pulse_out), 32'(exp_p));
            if (exp_p) chk("all4_id", 32'(pulse_id), 32'((c - 2) / 8));
        end
        chk("all4_ovf",  32'(ovf),  32'd0);
        chk("all4_busy", 32'(busy), 32'd0);

        // Saturate requester 2 with enable low.
        enable = 1'b0; req_pulse = 4'b0100;
        repeat (9) tick();
        req_pulse = '0;
        chk("sat_pending", 32'(pending), 32'b0100);
        chk("sat_ovf",     32'(ovf),     32'b0100);
        chk("sat_idle",    32'(busy),    32'd0);
        enable = 1'b1;
        npulse = 0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (pulse_out) begin
                npulse++;
                chk("sat_id", 32'(pulse_id), 32'd2);
            end
        end
        chk("sat_count",   32'(npulse),  32'd7);
        chk("sat_drained", 32'(pending), 32'd0);
        chk("sat_ovf_hold", 32'(ovf),    32'b0100);
        clr_ovf = 1'b1;
        tick(); clr_ovf = 1'b0;
        chk("clr_ovf", 32'(ovf), 32'd0);

        // Counter at 7 with inc in its own ISSUE cycle: count and ovf unchanged.
        enable = 1'b0; req_pulse = 4'b0010;
        repeat (7) tick();
        req_pulse = '0;
        chk("sd_ovf0",    32'(ovf),     32'd0);
        chk("sd_pending", 32'(pending), 32'b0010);
        enable = 1'b1;
        tick();
        chk("sd_issue", 32'(pulse_out), 32'd1);
        chk("sd_id",    32'(pulse_id),  32'd1);
        req_pulse = 4'b0010;
        tick(); req_pulse = '0;
        chk("sd_ovf1", 32'(ovf), 32'd0);
        npulse = 1;
        for (int c = 3; c <= 70; c++) begin
            tick();
            if (pulse_out) npulse++;
        end
        chk("sd_count", 32'(npulse), 32'd8);
        chk("sd_ovf2",  32'(ovf),    32'd0);

        // Fairness: last grant 3, then 0 and 3 pending -> 0 before 3.
        req_pulse = 4'b1000;
        tick(); req_pulse = '0;
        tick();
        chk("fair_first_pulse", 32'(pulse_out), 32'd1);
        chk("fair_first_id",    32'(pulse_id),  32'd3);
        tick(); req_pulse = 4'b1001;
        tick(); req_pulse = '0;
        repeat (6) tick();
        chk("fair_a_pulse", 32'(pulse_out), 32'd1);
        chk("fair_a_id",    32'(pulse_id),  32'd0);
        repeat (8) tick();
        chk("fair_b_pulse", 32'(pulse_out), 32'd1);
        chk("fair_b_id",    32'(pulse_id),  32'd3);
        repeat (8) tick();
        chk("fair_idle", 32'(busy), 32'd0);

        // Reset during GUARD aborts and discards pending work.
        enable = 1'b0; req_pulse = 4'b0100;
        repeat (8) tick();
        req_pulse = '0;
        chk("rg_ovf_pre", 32'(ovf), 32'b0100);
        enable = 1'b1;
        tick();
        chk("rg_issue", 32'(pulse_out), 32'd1);
        chk("rg_id",    32'(pulse_id),  32'd2);
        tick();
        tick();
        chk("rg_guard", 32'(busy), 32'd1);
        rstn = 1'b0;
        tick();
        chk("rg_pulse",   32'(pulse_out), 32'd0);
        chk("rg_busy",    32'(busy),      32'd0);
        chk("rg_pending", 32'(pending),   32'd0);
        chk("rg_ovf",     32'(ovf),       32'd0);
        chk("rg_id0",     32'(pulse_id),  32'd0);
        rstn = 1'b1;
        npulse = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (pulse_out) npulse++;
        end
        chk("rg_quiet", 32'(npulse), 32'd0);
        req_pulse = 4'b0001;
        tick(); req_pulse = '0;
        tick();
        chk("rg_new_pulse", 32'(pulse_out), 32'd1);
        chk("rg_new_id",    32'(pulse_id),  32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pulse_sync_sched.md
Name: pulse_sync_sched

Overview:
- Source-domain scheduler that lets NREQ independent pulse requesters share one cross-domain pulse-synchronizer channel.
- Counts pending pulses per requester and grants them round-robin.
- Issues one single-cycle pulse at a time with a stable channel ID.
- Enforces a guard gap between issued pulses so the destination-side synchronizer never merges two pulses.

Parameters:
- NREQ, 4, number of requesters.
- IDW, 2, width of pulse_id; must satisfy 2^IDW >= NREQ.
- CNTW, 3, width of each per-requester pending counter; saturates at 2^CNTW-1.
- GAP, 6, guard cycles after each issued pulse; legal range 1..15.

Ports:
- clk  input  1  single clock, rising edge.
- rstn  input  1  synchronous reset, active low.
- req_pulse  input  NREQ  per-requester event pulses; each high cycle is one event.
- enable  input  1  allows new grants when high.
- clr_ovf  input  1  clears all ovf bits.
- pulse_out  output  1  single-cycle pulse to the synchronizer channel.
- pulse_id  output  IDW  index of the requester served by the current or last pulse.
- busy  output  1  high in ISSUE and GUARD.
- pending  output  NREQ  bit i high when cnt[i] != 0.
- ovf  output  NREQ  sticky flag; bit i set when requester i lost an event to saturation.

Behaviour:
- Reset: sampled on clk when rstn=0. After that edge:
  - all counters = 0, state = IDLE;
  - pulse_out = 0, pulse_id = 0, busy = 0, pending = 0, ovf = 0;
  - round-robin pointer last = NREQ-1, so requester 0 has first priority.
- Reset mid-operation aborts ISSUE/GUARD immediately and discards all pending counts.
- Counters, per requester i, each cycle:
  - inc = req_pulse[i];
  - dec = (state==ISSUE && pulse_id==i).
- Counter rules:
  - inc & !dec: cnt+1 if not saturated; if saturated, cnt holds and ovf[i] <= 1.
  - !inc & dec: cnt-1.
  - inc & dec: cnt unchanged, including at saturation; ovf is not set.
  - dec never occurs with cnt=0.
- ovf: clr_ovf clears all bits. A set condition in the same cycle as clr_ovf wins; that bit stays 1.
- FSM states: IDLE, ISSUE, GUARD.
- IDLE:
  - if enable && pending != 0, select the first i with pending[i], searching from last+1 upward with wrap;
  - register pulse_id <= i, last <= i, go to ISSUE;
  - otherwise stay in IDLE.
  - pending is taken from registered counters, so an event arriving in the same cycle is not yet visible.
- ISSUE:
  - lasts exactly 1 cycle; pulse_out = 1 (decode of state register, glitch-free);
  - decrements the granted counter;
  - load gap counter = GAP-1, go to GUARD.
- GUARD:
  - lasts GAP cycles; pulse_id held;
  - at gap counter = 0, go to IDLE; otherwise decrement.
- enable:
  - affects only the IDLE grant decision;
  - deasserting it during ISSUE/GUARD lets the current sequence complete;
  - counters keep accumulating while enable is low.
- Latency: req_pulse high in cycle 0 with the FSM idle → pulse_out high in cycle 2.
- Minimum spacing between rising edges of pulse_out = GAP+2 cycles (ISSUE + GAP + IDLE).
- pulse_id is stable from the cycle pulse_out rises until the next grant, at least GAP+1 cycles after the pulse. It may be sent as quasi-static data alongside the pulse.
- Outputs:
  - busy = (state != IDLE);
  - pending is a combinational OR-reduce of each registered counter.

Decomposition:
- Shared package holds:
  - the FSM state encoding (IDLE=2'd0, ISSUE=2'd1, GUARD=2'd2);
  - a function for the round-robin next-index search.
- Natural sub-module: pulse_pend_cnt, one saturating up/down counter with overflow flag, instantiated NREQ times via generate.
- Arbiter and FSM stay in the top level.

Test Plan:
- Reset, then req_pulse=4'b0001 for one cycle at cycle 0:
  - pulse_out=1 only in cycle 2, pulse_id=0;
  - busy high in cycles 2..8;
  - pending[0] drops after cycle 2.
- req_pulse=4'b1111 in a single cycle:
  - four pulses with pulse_id 0,1,2,3;
  - rising edges exactly 8 cycles apart (GAP=6);
  - no ovf.
- Requester 2 pulses 9 times back-to-back with enable=0:
  - cnt[2] saturates at 7 and ovf[2]=1;
  - raise enable: exactly 7 pulses with id 2;
  - clr_ovf clears ovf[2].
- cnt[1]=7 and req_pulse[1] high in its own ISSUE cycle: cnt stays 7, ovf[1] stays 0.
- Fairness: last grant = 3, then requesters 0 and 3 both pending → next grant is 0, then 3.
- Assert rstn=0 during GUARD:
  - next edge: pulse_out=0, busy=0, pending=0, ovf=0;
  - no pulse issued until a new req_pulse arrives after reset is released.
